// File: rtl/violation_uplink_tx_pkg.sv
// Shared definitions for the violation uplink transmitter.
//  - Default field widths of a record word R = {board, id, time}. The board
//    field sits in the MSBs and the time field in the LSBs, so rec_time[0]
//    is the first data bit on the line.
//  - Frame state encodings and the line idle level.
package violation_uplink_tx_pkg;

  localparam int BOARD_W_DEF = 3;
  localparam int ID_W_DEF    = 5;
  localparam int TIME_W_DEF  = 19;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/violation_uplink_tx_fifo.sv
// violation_fifo: synchronous FIFO with an occupancy count.
// Ports:
//  clk, reset            clock, synchronous active-high reset
//  wr_en_i, wr_data_i    write request/data (ignored while full)
//  rd_en_i, rd_data_o    read request, head word (valid while !empty_o)
//  count_o               occupancy, 0..DEPTH
//  full_o, empty_o       status flags
module violation_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 27
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en_i,
  input  logic [W-1:0]               wr_data_i,
  input  logic                       rd_en_i,
  output logic [W-1:0]               rd_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_ok, rd_ok;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign rd_data_o = mem_q[rd_ptr_q];

  assign wr_ok = wr_en_i & ~full_o;
  assign rd_ok = rd_en_i & ~empty_o;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(wr_ok) - CW'(rd_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the count gates every read.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign count_o = count_q;

endmodule

// File: rtl/violation_uplink_tx.sv
// violation_uplink_tx: buffers violation records and sends each one as a
// serial frame: START(0), REC_W data bits LSB first, even parity, STOP(1).
// Every bit is held for BIT_CYCLES clocks; the line idles high.
// Ports:
//  clk, reset                         clock, synchronous active-high reset
//  rec_valid/rec_ready                record handshake (ready = FIFO not full)
//  rec_board, rec_id, rec_time        record fields (id 0 is rejected)
//  tx_line                            registered serial output
//  tx_busy                            frame in progress
//  pending                            FIFO occupancy
//  overflow, clr_overflow             sticky record-lost flag and its clear
module violation_uplink_tx
  import violation_uplink_tx_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int BOARD_W    = BOARD_W_DEF,
  parameter int ID_W       = ID_W_DEF,
  parameter int TIME_W     = TIME_W_DEF,
  parameter int BIT_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rec_valid,
  output logic                   rec_ready,
  input  logic [BOARD_W-1:0]     rec_board,
  input  logic [ID_W-1:0]        rec_id,
  input  logic [TIME_W-1:0]      rec_time,
  output logic                   tx_line,
  output logic                   tx_busy,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   overflow,
  input  logic                   clr_overflow
);

  localparam int REC_W = BOARD_W + ID_W + TIME_W;
  localparam int CW    = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int IW    = $clog2(REC_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(REC_W - 1);

  logic [REC_W-1:0] rec_word, head;
  logic             full, empty, push, loss, pop, last;

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [REC_W-1:0] shreg_q, shreg_d;
  logic             par_q, par_d;
  logic             tx_q, tx_d;
  logic             ovf_q, ovf_d;

  assign rec_word  = {rec_board, rec_id, rec_time};
  assign rec_ready = ~full;
  assign push      = rec_valid & ~full & (rec_id != '0);
  assign loss      = rec_valid & (full | (rec_id == '0));

  violation_fifo #(.DEPTH(DEPTH), .W(REC_W)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (push),
    .wr_data_i (rec_word),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .count_o   (pending),
    .full_o    (full),
    .empty_o   (empty)
  );

  // tx_d is the line level for the state being entered, so the output
  // register always matches state_q without a combinational path.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    last    = (cnt_q == CNT_LAST);
    if (state_q != ST_IDLE) cnt_d = last ? '0 : cnt_q + CW'(1);
    case (state_q)
      ST_IDLE: if (!empty) begin
        pop     = 1'b1;
        shreg_d = head;
        par_d   = ^head;
        idx_d   = '0;
        cnt_d   = '0;
        state_d = ST_START;
        tx_d    = 1'b0;
      end
      ST_START: if (last) begin
        state_d = ST_DATA;
        tx_d    = shreg_q[0];
      end
      ST_DATA: if (last) begin
        if (idx_q == IDX_LAST) begin
          state_d = ST_PARITY;
          tx_d    = par_q;
        end else begin
          idx_d   = idx_q + IW'(1);
          shreg_d = shreg_q >> 1;
          tx_d    = shreg_q[1];
        end
      end
      ST_PARITY: if (last) begin
        state_d = ST_STOP;
        tx_d    = LINE_IDLE;
      end
      ST_STOP: if (last) begin
        state_d = ST_IDLE;
        tx_d    = LINE_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = LINE_IDLE;
      end
    endcase
  end

  // A new loss wins over a simultaneous clear.
  assign ovf_d = loss | (ovf_q & ~clr_overflow);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= LINE_IDLE;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tx_line  = tx_q;
  assign tx_busy  = (state_q != ST_IDLE);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_violation_uplink_tx.sv
// Directed bench for violation_uplink_tx at default parameters.
module tb_violation_uplink_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        rec_valid;
  logic        rec_ready;
  logic [2:0]  rec_board;
  logic [4:0]  rec_id;
  logic [18:0] rec_time;
  logic        tx_line;
  logic        tx_busy;
  logic [4:0]  pending;
  logic        overflow;
  logic        clr_overflow;

  int n_chk = 0;
  int n_err = 0;

  violation_uplink_tx dut (
    .clk          (clk),
    .reset        (reset),
    .rec_valid    (rec_valid),
    .rec_ready    (rec_ready),
    .rec_board    (rec_board),
    .rec_id       (rec_id),
    .rec_time     (rec_time),
    .tx_line      (tx_line),
    .tx_busy      (tx_busy),
    .pending      (pending),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] b, input logic [4:0] id, input logic [18:0] t);
    rec_valid = 1'b1;
    rec_board = b;
    rec_id    = id;
    rec_time  = t;
    tick();
    rec_valid = 1'b0;
  endtask

  task automatic push_rec(input logic [26:0] r);
    push(r[26:24], r[23:19], r[18:0]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [26:0] rec6(input int i);
    logic [2:0] b;
    b = 3'(i % 5);
    return {b, 5'(i + 1), 19'(i * 1000 + 7)};
  endfunction

  // Waits (bounded) for the start bit, captures 120 line samples, decodes.
  // Ends at the sample right after the frame, where the line must be high.
  task automatic get_frame(input string tag, input logic [26:0] exp, output int nwait);
    logic        line [120];
    logic [26:0] d;
    logic        stable;
    int          w;
    w = 0;
    while (tx_line !== 1'b0 && w < 400) begin
      tick();
      w++;
    end
    nwait = w;
    if (tx_line !== 1'b0) begin
      chk({tag, "_start_timeout"}, 32'(tx_line), 32'd0);
      return;
    end
    for (int c = 0; c < 120; c++) begin
      line[c] = tx_line;
      tick();
    end
    stable = 1'b1;
    for (int b = 0; b < 30; b++)
      for (int k = 1; k < 4; k++)
        if (line[b*4+k] !== line[b*4]) stable = 1'b0;
    for (int i = 0; i < 27; i++) d[i] = line[4 + 4*i];
    chk({tag, "_start"},  32'(line[0]),   32'd0);
    chk({tag, "_data"},   32'(d),         32'(exp));
    chk({tag, "_parity"}, 32'(line[112]), 32'(^exp));
    chk({tag, "_stop"},   32'(line[116]), 32'd1);
    chk({tag, "_stable"}, 32'(stable),    32'd1);
    chk({tag, "_idle"},   32'(tx_line),   32'd1);
  endtask

  initial begin
    int w, w2, w3, lows, extra;
    reset = 1'b1; rec_valid = 1'b0; rec_board = '0; rec_id = '0;
    rec_time = '0; clr_overflow = 1'b0;
    do_reset();

    // reset state
    chk("rst_tx",    32'(tx_line),   32'd1);
    chk("rst_busy",  32'(tx_busy),   32'd0);
    chk("rst_pend",  32'(pending),   32'd0);
    chk("rst_ovf",   32'(overflow),  32'd0);
    chk("rst_ready", 32'(rec_ready), 32'd1);

    // 1: single record, latency and frame content
    push(3'd2, 5'd7, 19'd100);
    chk("t1_pend1", 32'(pending), 32'd1);
    chk("t1_tx_hi", 32'(tx_line), 32'd1);
    get_frame("t1", 27'b010_00111_0000000000001100100, w);
    chk("t1_wait", 32'(w), 32'd1);
    chk("t1_pend0", 32'(pending), 32'd0);
    chk("t1_busy0", 32'(tx_busy), 32'd0);

    // 2: fill to full (first record drains into the shifter at once)
    do_reset();
    for (int i = 0; i < 16; i++) push(3'd1, 5'(i + 1), 19'(i));
    chk("t2_pend15", 32'(pending),   32'd15);
    chk("t2_ready1", 32'(rec_ready), 32'd1);
    push(3'd1, 5'd17, 19'd16);
    chk("t2_pend16", 32'(pending),   32'd16);
    chk("t2_ready0", 32'(rec_ready), 32'd0);
    chk("t2_ovf0",   32'(overflow),  32'd0);
    push(3'd1, 5'd18, 19'd17);
    chk("t2_ovf1",   32'(overflow),  32'd1);
    chk("t2_pend_k", 32'(pending),   32'd16);
    clr_overflow = 1'b1;
    push(3'd1, 5'd19, 19'd18);
    chk("t2_clr_loss", 32'(overflow), 32'd1);
    tick();
    clr_overflow = 1'b0;
    chk("t2_clr", 32'(overflow), 32'd0);

    // 3: id 0 rejected
    do_reset();
    push(3'd3, 5'd0, 19'd5);
    chk("t3_ovf",  32'(overflow), 32'd1);
    chk("t3_pend", 32'(pending),  32'd0);
    tick(); tick();
    chk("t3_busy", 32'(tx_busy),  32'd0);
    chk("t3_tx",   32'(tx_line),  32'd1);

    // 4: three back-to-back frames
    do_reset();
    push(3'd0, 5'd1, 19'h7_FFFF);
    fork
      begin
        get_frame("t4a", {3'd0, 5'd1, 19'h7_FFFF}, w);
        get_frame("t4b", {3'd4, 5'd31, 19'h5_5555}, w2);
        chk("t4b_gap", 32'(w2), 32'd1);
        get_frame("t4c", {3'd1, 5'd16, 19'd0}, w3);
        chk("t4c_gap", 32'(w3), 32'd1);
      end
      begin
        push(3'd4, 5'd31, 19'h5_5555);
        push(3'd1, 5'd16, 19'd0);
      end
    join
    chk("t4_pend0", 32'(pending), 32'd0);

    // 5: reset in the DATA state
    do_reset();
    push(3'd2, 5'd3, 19'd9);
    push(3'd2, 5'd4, 19'd10);
    chk("t5_pend1", 32'(pending), 32'd1);
    for (int i = 0; i < 10; i++) tick();
    chk("t5_busy", 32'(tx_busy), 32'd1);
    reset = 1'b1;
    tick();
    chk("t5_tx",   32'(tx_line), 32'd1);
    chk("t5_pend", 32'(pending), 32'd0);
    chk("t5_idle", 32'(tx_busy), 32'd0);
    reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (tx_line !== 1'b1) lows++;
    end
    chk("t5_silent", 32'(lows), 32'd0);

    // 6: push+pop at pending=3, pointer wrap, ordering
    do_reset();
    extra = 0;
    push_rec(rec6(0));
    fork
      begin
        for (int n = 0; n < 18; n++) begin
          get_frame($sformatf("t6_%0d", n), rec6(n), w);
          if (pending == 5'd3 && extra < 4) begin
            push_rec(rec6(14 + extra));
            chk($sformatf("t6_pp%0d", extra), 32'(pending), 32'd3);
            extra++;
          end
        end
      end
      begin
        for (int i = 1; i < 14; i++) push_rec(rec6(i));
      end
    join
    chk("t6_extra", 32'(extra),   32'd4);
    chk("t6_pend0", 32'(pending), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
